// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory access stage.
package mem_access_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// BUSY-cycle counter with synchronous clear and terminal-count flag.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_M1 = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == TC_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !tc)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Unified memory port stage: one req/ack access per control strobe.
// Optional BUSY timeout abort enabled by MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemR,
  input  logic              MemW,
  input  logic              IRWrite,
  input  logic              IoD,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic              Stall,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MDR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] load;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              cmd, start, busy, abort;

  assign cmd   = MemW | MemR | IRWrite;
  assign start = (state_q == S_IDLE) && cmd;
  assign busy  = (state_q == S_BUSY);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .CLK  (CLK),
    .Reset(Reset),
    .clr  (start),
    .en   (busy),
    .tc   (abort)
  );
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    req_d   = 1'b0;
    err_d   = 1'b0;
    Stall   = 1'b0;
    load    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd) begin
          Stall   = 1'b1;
          state_d = S_BUSY;
          req_d   = 1'b1;
          addr_d  = IoD ? ALUOut : PC;
          wdata_d = WriteData;
          we_d    = MemW;
          priority case (1'b1)
            MemW:    kind_d = K_STORE;
            MemR:    kind_d = K_LOAD;
            default: kind_d = K_FETCH;
          endcase
        end
      end
      S_BUSY: begin
        Stall = 1'b1;
        req_d = 1'b1;
        if (mem_ack || abort) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = !mem_ack;
          // an aborted read leaves zero in its destination
          load    = mem_ack ? mem_rdata : '0;
          if (kind_q == K_FETCH)
            ir_d = load;
          if (kind_q == K_LOAD)
            mdr_d = load;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign IR        = ir_q;
  assign MDR       = mdr_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

endmodule
